// File: rtl/gat_layer_scheduler.sv
// gat_layer_scheduler: arms wrapper BRAM load flags, waits for gat_ready, drains new-feature BRAM as a stream.
// Define GAT_SCHED_TIMEOUT_EN to add the RUN watchdog, ERR state and sticky err output.
module gat_layer_scheduler #(
  parameter int NEW_FEATURE_WIDTH = 32,
  parameter int NEW_FEATURE_DEPTH = 43328,
  parameter int FEAT_ADDR_W       = 16,
  parameter int RD_LAT            = 2,
  parameter int TIMEOUT_CYCLES    = 2**24
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_start,
  input  logic                         cmd_layer,
  input  logic                         host_h_data_done,
  input  logic                         host_node_info_done,
  input  logic                         host_wgt_done,
  output logic                         gat_layer,
  output logic                         h_data_bram_load_done,
  output logic                         h_node_info_bram_load_done,
  output logic                         wgt_bram_load_done,
  input  logic                         gat_ready,
  output logic [FEAT_ADDR_W+1:0]       feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0] feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0] m_feat_data,
  output logic                         m_feat_valid,
  input  logic                         m_feat_ready,
  output logic                         m_feat_last,
`ifdef GAT_SCHED_TIMEOUT_EN
  output logic                         err,
`endif
  output logic                         busy,
  output logic                         done
);
  localparam int FD = RD_LAT + 2;
  localparam int PW = $clog2(FD);
  localparam int CW = $clog2(FD + 1);
  localparam logic [FEAT_ADDR_W-1:0] LAST_IDX = FEAT_ADDR_W'(NEW_FEATURE_DEPTH - 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(FD - 1);

  typedef enum logic [2:0] {IDLE, WAIT_LOAD, ARM, RUN, DRAIN, DONE, ERR} state_t;
  state_t state_q, state_d;
  logic gat_layer_q, armed_q, issued_all_q, start_ok, issue, push, pop, load_on, timeout;
  logic [FEAT_ADDR_W-1:0] rd_idx_q;
  logic [RD_LAT-1:0] vld_pipe_q, last_pipe_q;
  logic [NEW_FEATURE_WIDTH:0] fifo_q [FD];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;

  // A read is issued only when every in-flight word already has a reserved FIFO slot.
  always_comb begin
    start_ok = cmd_start && (state_q == IDLE || state_q == DONE || state_q == ERR);
    issue = state_q == DRAIN && !issued_all_q && ($countones(vld_pipe_q) + int'(cnt_q) < FD);
    push = vld_pipe_q[RD_LAT-1];
    pop = m_feat_valid && m_feat_ready;
    state_d = state_q;
    case (state_q)
      WAIT_LOAD: state_d = (host_h_data_done && host_node_info_done && host_wgt_done) ? ARM : WAIT_LOAD;
      ARM:       state_d = RUN;
      RUN:       state_d = (armed_q && gat_ready) ? DRAIN : timeout ? ERR : RUN;
      DRAIN:     state_d = (pop && m_feat_last) ? DONE : DRAIN;
      default:   state_d = start_ok ? WAIT_LOAD : state_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gat_layer_q  <= 1'b0;
      armed_q      <= 1'b0;
      issued_all_q <= 1'b0;
      rd_idx_q     <= '0;
      vld_pipe_q   <= '0;
      last_pipe_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) gat_layer_q <= cmd_layer;
      // A gat_ready still high from the previous layer must be seen low before it counts.
      armed_q <= state_q == RUN && (armed_q || !gat_ready);
      if (state_q == RUN && state_d == DRAIN) begin
        rd_idx_q     <= '0;
        issued_all_q <= 1'b0;
      end else if (issue) begin
        issued_all_q <= rd_idx_q == LAST_IDX;
        rd_idx_q     <= (rd_idx_q == LAST_IDX) ? rd_idx_q : rd_idx_q + 1'b1;
      end
      vld_pipe_q  <= RD_LAT'({vld_pipe_q, issue});
      last_pipe_q <= RD_LAT'({last_pipe_q, issue && rd_idx_q == LAST_IDX});
      if (push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {last_pipe_q[RD_LAT-1], feat_bram_dout};
  end

`ifdef GAT_SCHED_TIMEOUT_EN
  logic [31:0] wd_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else wd_q <= (state_q == RUN) ? wd_q + 1'b1 : '0;
  end
  assign timeout = wd_q == 32'(TIMEOUT_CYCLES - 1);
  assign err = state_q == ERR;
`else
  assign timeout = 1'b0;
`endif

  assign load_on = state_q == ARM || state_q == RUN || state_q == DRAIN;
  assign h_data_bram_load_done = load_on;
  assign h_node_info_bram_load_done = load_on;
  assign wgt_bram_load_done = load_on;
  assign busy = load_on || state_q == WAIT_LOAD;
  assign done = state_q == DONE;
  assign gat_layer = gat_layer_q;
  assign feat_bram_addrb = {rd_idx_q, 2'b00};
  assign m_feat_valid = cnt_q != '0;
  assign {m_feat_last, m_feat_data} = m_feat_valid ? fifo_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_gat_layer_scheduler.sv
// tb_gat_layer_scheduler: scoreboard bench for gat_layer_scheduler using a reduced drain depth.
// With GAT_SCHED_TIMEOUT_EN defined the watchdog is shortened to 64 cycles and exercised.
module tb_gat_layer_scheduler;
  localparam int W = 32;
  localparam int DEPTH = 1200;
  localparam int AW = 11;
  localparam int RD_LAT = 2;
`ifdef GAT_SCHED_TIMEOUT_EN
  localparam int TMO = 64;
`else
  localparam int TMO = 1 << 24;
`endif

  logic clk = 0, rst_n = 0, cmd_start = 0, cmd_layer = 0;
  logic h_done = 0, n_done = 0, w_done = 0, gat_ready = 0, m_feat_ready = 0;
  logic gat_layer, ld_h, ld_n, ld_w, m_feat_valid, m_feat_last, busy, done;
  logic [AW+1:0] addrb;
  logic [W-1:0] dout, m_feat_data;
`ifdef GAT_SCHED_TIMEOUT_EN
  logic err;
`endif
  logic [AW+1:0] ap [RD_LAT];
  logic [W:0] sb [$];
  int checks = 0, failures = 0;

  function automatic logic [W-1:0] bdata(input logic [AW+1:0] a);
    return 32'hC0DE0000 | {{(W-AW-2){1'b0}}, a};
  endfunction

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ap[0] <= addrb;
    for (int i = 1; i < RD_LAT; i++) ap[i] <= ap[i-1];
  end
  assign dout = bdata(ap[RD_LAT-1]);

  gat_layer_scheduler #(
    .NEW_FEATURE_WIDTH(W), .NEW_FEATURE_DEPTH(DEPTH), .FEAT_ADDR_W(AW),
    .RD_LAT(RD_LAT), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_layer(cmd_layer),
    .host_h_data_done(h_done), .host_node_info_done(n_done), .host_wgt_done(w_done),
    .gat_layer(gat_layer), .h_data_bram_load_done(ld_h),
    .h_node_info_bram_load_done(ld_n), .wgt_bram_load_done(ld_w),
    .gat_ready(gat_ready), .feat_bram_addrb(addrb), .feat_bram_dout(dout),
    .m_feat_data(m_feat_data), .m_feat_valid(m_feat_valid), .m_feat_ready(m_feat_ready),
    .m_feat_last(m_feat_last),
`ifdef GAT_SCHED_TIMEOUT_EN
    .err(err),
`endif
    .busy(busy), .done(done)
  );

  task automatic do_start(input logic layer);
    cmd_layer = layer;
    cmd_start = 1;
    @(posedge clk); #1;
    cmd_start = 0;
  endtask

  task automatic run_drain(input int duty, input int stop_at, input bit chk_lat);
    int words, first, k;
    logic stall;
    logic [W:0] held, exp;
    words = 0; first = -1; stall = 0; held = '0;
    for (int i = 0; i < DEPTH; i++) sb.push_back({i == DEPTH - 1, bdata((AW+2)'(i) << 2)});
    gat_ready = 1;
    for (k = 0; k < 5 * DEPTH; k++) begin
      m_feat_ready = duty >= 100 || $urandom_range(99) < duty;
      if (chk_lat && k == 1) begin
        checks++;
        if (addrb !== '0) begin failures++; $display("FAIL drain_start_addr got=%0d want=0", addrb); end
      end
      if (stall) begin
        checks++;
        if ({m_feat_valid, m_feat_last, m_feat_data} !== {1'b1, held}) begin
          failures++;
          $display("FAIL stall_hold got=%b/%b/%h want=1/%h", m_feat_valid, m_feat_last, m_feat_data, held);
        end
      end
      if (m_feat_valid && first < 0) first = k;
      stall = m_feat_valid && !m_feat_ready;
      held = {m_feat_last, m_feat_data};
      if (m_feat_valid && m_feat_ready) begin
        exp = (sb.size() != 0) ? sb.pop_front() : '1;
        checks++;
        if ({m_feat_last, m_feat_data} !== exp) begin
          failures++;
          $display("FAIL beat%0d got=%h want=%h", words, {m_feat_last, m_feat_data}, exp);
        end
        words++;
        if (m_feat_last || words == stop_at) break;
      end
      @(posedge clk); #1;
    end
    if (k >= 5 * DEPTH) begin failures++; $display("FAIL drain_budget got=%0d words want=%0d", words, stop_at); end
    if (stop_at >= DEPTH) begin
      @(posedge clk); #1;
      checks++;
      if (words !== DEPTH) begin failures++; $display("FAIL word_count got=%0d want=%0d", words, DEPTH); end
      checks++;
      if ({done, busy, m_feat_valid, ld_h, ld_n, ld_w} !== 6'b100000) begin
        failures++;
        $display("FAIL done_state got=%b want=100000", {done, busy, m_feat_valid, ld_h, ld_n, ld_w});
      end
    end
    if (chk_lat) begin
      checks++;
      if (first !== RD_LAT + 2) begin failures++; $display("FAIL first_valid_latency got=%0d want=%0d", first, RD_LAT + 2); end
    end
    m_feat_ready = 0;
    gat_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if ({gat_layer, ld_h, ld_n, ld_w, addrb, m_feat_data, m_feat_valid, m_feat_last} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b%b%b%b/%h/%h/%b%b want=0", gat_layer, ld_h, ld_n, ld_w, addrb, m_feat_data, m_feat_valid, m_feat_last);
    end
    checks++;
    if ({busy, done} !== 2'b00) begin failures++; $display("FAIL reset_busy_done got=%b want=00", {busy, done}); end
  endtask

  task automatic test_nominal();
    {h_done, n_done, w_done} = 3'b111;
    gat_ready = 0;
    do_start(1'b1);
    checks++;
    if ({gat_layer, busy, done, ld_h, ld_n, ld_w} !== 6'b110000) begin
      failures++;
      $display("FAIL wait_load got=%b want=110000", {gat_layer, busy, done, ld_h, ld_n, ld_w});
    end
    @(posedge clk); #1;
    checks++;
    if ({ld_h, ld_n, ld_w, busy} !== 4'b1111) begin failures++; $display("FAIL arm_load_done got=%b want=1111", {ld_h, ld_n, ld_w, busy}); end
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if ({m_feat_valid, busy} !== 2'b01) begin failures++; $display("FAIL run_wait got=%b want=01", {m_feat_valid, busy}); end
    run_drain(100, DEPTH, 1);
    checks++;
    if (gat_layer !== 1'b1) begin failures++; $display("FAIL gat_layer_hold got=%b want=1", gat_layer); end
  endtask

  task automatic test_partial();
    int bad;
    {h_done, n_done, w_done} = 3'b101;
    gat_ready = 0;
    do_start(1'b0);
    checks++;
    if ({done, gat_layer} !== 2'b00) begin failures++; $display("FAIL restart_clear got=%b want=00", {done, gat_layer}); end
    bad = 0;
    repeat (500) begin
      if ({ld_h, ld_n, ld_w} !== 3'b000 || busy !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL partial_hold got=%0d bad cycles want=0", bad); end
    n_done = 1;
    checks++;
    if ({ld_h, ld_n, ld_w} !== 3'b000) begin failures++; $display("FAIL pre_arm got=%b want=000", {ld_h, ld_n, ld_w}); end
    @(posedge clk); #1;
    checks++;
    if ({ld_h, ld_n, ld_w} !== 3'b111) begin failures++; $display("FAIL arm_after_node got=%b want=111", {ld_h, ld_n, ld_w}); end
    repeat (2) @(posedge clk);
    #1;
    run_drain(100, DEPTH, 1);
  endtask

  task automatic test_backpressure();
    {h_done, n_done, w_done} = 3'b111;
    gat_ready = 0;
    do_start(1'b0);
    repeat (5) @(posedge clk);
    #1;
    run_drain(30, DEPTH, 1);
  endtask

  task automatic test_stale_ready();
    int early;
    {h_done, n_done, w_done} = 3'b111;
    gat_ready = 1;
    do_start(1'b1);
    early = 0;
    repeat (60) begin
      if (m_feat_valid) early++;
      @(posedge clk); #1;
    end
    checks++;
    if (early !== 0 || {busy, ld_h, ld_n, ld_w} !== 4'b1111) begin
      failures++;
      $display("FAIL stale_ready got=%0d valid cycles, state %b want=0, 1111", early, {busy, ld_h, ld_n, ld_w});
    end
    gat_ready = 0;
    @(posedge clk); #1;
    run_drain(100, DEPTH, 1);
  endtask

  task automatic test_reset_mid_drain();
    {h_done, n_done, w_done} = 3'b111;
    gat_ready = 0;
    do_start(1'b0);
    repeat (5) @(posedge clk);
    #1;
    run_drain(100, 1000, 0);
    rst_n = 0;
    #1;
    checks++;
    if ({m_feat_valid, m_feat_last, busy, done, ld_h, ld_n, ld_w} !== 7'b0) begin
      failures++;
      $display("FAIL async_flush got=%b want=0000000", {m_feat_valid, m_feat_last, busy, done, ld_h, ld_n, ld_w});
    end
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    do_start(1'b1);
    repeat (5) @(posedge clk);
    #1;
    run_drain(100, DEPTH, 1);
  endtask

`ifdef GAT_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    {h_done, n_done, w_done} = 3'b111;
    gat_ready = 0;
    do_start(1'b0);
    repeat (65) @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL err_early got=%b want=0", err); end
    @(posedge clk); #1;
    checks++;
    if ({err, busy, ld_h, ld_n, ld_w} !== 5'b10000) begin
      failures++;
      $display("FAIL err_state got=%b want=10000", {err, busy, ld_h, ld_n, ld_w});
    end
    do_start(1'b0);
    checks++;
    if ({err, busy} !== 2'b01) begin failures++; $display("FAIL err_clear got=%b want=01", {err, busy}); end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_partial();
    test_backpressure();
    test_stale_ready();
    test_reset_mid_drain();
`ifdef GAT_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=%0d checks want=finish", checks);
    $fatal(1, "simulation time limit");
  end
endmodule
